// File: rtl/raman_pkg.sv
// Shared widths, FSM state encoding and a sizing helper for the point accumulator.
package raman_pkg;

    localparam int DATA_W = 14;
    localparam int SUM_W  = DATA_W + 17;
    localparam int IDX_W  = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DUMP = 2'd2
    } state_e;

    // Address width for a table of 'depth' entries, never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/point_accumulator_if.sv
// Summed-point output stream: valid/ready handshake carrying a sum and its point index.
interface point_accumulator_if
    import raman_pkg::*;
#(
    parameter int DW = SUM_W,
    parameter int IW = IDX_W
);

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_index;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        output out_ready
    );

endinterface

// File: rtl/acc_ram.sv
// Simple dual-port accumulation RAM: one write port, one registered read port.
module acc_ram
    import raman_pkg::*;
#(
    parameter int DEPTH  = 11,
    parameter int WIDTH  = SUM_W,
    parameter int ADDR_W = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Write port and registered read; a same-cycle read returns the old contents.
    // NOTE: the array has no reset: sweep 0 overwrites every entry before it is read,
    // and a reset term would stop the array mapping onto a RAM macro.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/point_accumulator.sv
// Point accumulator: sums MEASURES sweeps of POINTS+1 samples into a RAM, then
// streams the per-point sums out over a valid/ready interface.
module point_accumulator #(
    parameter int POINTS   = 10,
    parameter int MEASURES = 100,
    parameter int DATA_W   = raman_pkg::DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdreq,
    input  logic [DATA_W-1:0]   data_in,
    point_accumulator_if.master out_if,
    output logic                busy,
    output logic                frame_done,
    output logic                ovf_err
);

    import raman_pkg::state_e;
    import raman_pkg::IDLE;
    import raman_pkg::ACC;
    import raman_pkg::DUMP;
    import raman_pkg::IDX_W;
    import raman_pkg::addr_width;

    localparam int SUM_W  = DATA_W + 17;
    localparam int ADDR_W = addr_width(POINTS + 1);
    localparam int SW_W   = addr_width(MEASURES + 1);

    localparam logic [IDX_W-1:0] LAST_PT = IDX_W'(POINTS);
    localparam logic [SW_W-1:0]  LAST_SW = SW_W'(MEASURES);
    localparam logic [1:0]       GAP_MIN = 2'd2;

    // Control state
    state_e             state_q, state_d;
    logic               smp_v_q, smp_v_d;
    logic [IDX_W-1:0]   pt_q, pt_d;
    logic [SW_W-1:0]    sw_q, sw_d;
    logic [1:0]         gap_q, gap_d;
    logic [IDX_W-1:0]   dump_idx_q, dump_idx_d;
    logic               out_valid_q, out_valid_d;
    logic               frame_done_q, frame_done_d;
    logic               ovf_err_q, ovf_err_d;

    // Read-modify-write pipeline
    logic               s1_v_q, s1_v_d;
    logic               s1_first_q, s1_first_d;
    logic [ADDR_W-1:0]  s1_addr_q, s1_addr_d;
    logic [DATA_W-1:0]  s1_data_q, s1_data_d;
    logic               fwd_v_q, fwd_v_d;
    logic [ADDR_W-1:0]  fwd_addr_q, fwd_addr_d;
    logic [SUM_W-1:0]   fwd_data_q, fwd_data_d;
    logic [SUM_W-1:0]   rmw_base;

    // RAM ports
    logic               ram_we;
    logic [ADDR_W-1:0]  ram_waddr;
    logic [SUM_W-1:0]   ram_wdata;
    logic [ADDR_W-1:0]  ram_raddr;
    logic [SUM_W-1:0]   ram_rdata;

    // Per-cycle event decode
    logic               accept;
    logic               dump_last;
    logic               take;
    logic               drop;
    logic               close_sweep;
    logic               early;

    acc_ram #(
        .DEPTH  (POINTS + 1),
        .WIDTH  (SUM_W),
        .ADDR_W (ADDR_W)
    ) u_acc_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata),
        .rd_addr (ram_raddr),
        .rd_data (ram_rdata)
    );

    // Classify the current sample and the output handshake.
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        smp_v_d     = rdreq;
        accept      = out_valid_q & out_if.out_ready;
        dump_last   = (dump_idx_q == LAST_PT);
        take        = 1'b0;
        if (smp_v_q) begin
            if (state_q == IDLE) begin
                take = 1'b1;
            end else if ((state_q == ACC) && (sw_q != LAST_SW)) begin
                take = 1'b1;
            end
        end
        drop        = smp_v_q & ~take;
        close_sweep = take & (pt_q == LAST_PT);
        early       = take && (state_q == ACC) && (pt_q == '0) &&
                      (sw_q != '0) && (gap_q != GAP_MIN);
    end

    // Next-state logic: start on the first sample, dump once all sweeps are in.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (take) state_d = ACC;
            ACC:     if (sw_q == LAST_SW) state_d = DUMP;
            DUMP:    if (accept && dump_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Point, sweep and inter-sweep gap counters.
    always_comb begin
        pt_d  = pt_q;
        sw_d  = sw_q;
        gap_d = gap_q;
        if (close_sweep) begin
            pt_d  = '0;
            sw_d  = sw_q + SW_W'(1);
            gap_d = '0;
        end else begin
            if (take) begin
                pt_d = pt_q + IDX_W'(1);
            end
            if (!smp_v_q && (gap_q != GAP_MIN)) begin
                gap_d = gap_q + 2'd1;
            end
        end
        if ((state_q == DUMP) && accept && dump_last) begin
            pt_d = '0;
            sw_d = '0;
        end
    end

    // Accumulate path: capture sample, then write overwrite/sum one cycle later.
    // A write to the address being read back on the next sample is forwarded,
    // which only matters when a sweep is a single point long.
    always_comb begin
        s1_v_d     = take;
        s1_first_d = (sw_q == '0);
        s1_addr_d  = pt_q[ADDR_W-1:0];
        s1_data_d  = data_in;
        rmw_base   = (fwd_v_q && (fwd_addr_q == s1_addr_q)) ? fwd_data_q : ram_rdata;
        ram_we     = s1_v_q;
        ram_waddr  = s1_addr_q;
        ram_wdata  = s1_first_q ? SUM_W'(s1_data_q) : rmw_base + SUM_W'(s1_data_q);
        fwd_v_d    = s1_v_q;
        fwd_addr_d = s1_addr_q;
        fwd_data_d = ram_wdata;
    end

    // Dump sequencing; the RAM reads the upcoming index so data tracks the index.
    always_comb begin
        dump_idx_d   = dump_idx_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        if (state_q == DUMP) begin
            out_valid_d = ~(accept & dump_last);
            if (accept) begin
                dump_idx_d   = dump_last ? '0 : dump_idx_q + IDX_W'(1);
                frame_done_d = dump_last;
            end
        end
        ram_raddr = (state_q == DUMP) ? dump_idx_d[ADDR_W-1:0] : pt_q[ADDR_W-1:0];
    end

    // Sticky error: dropped sample or sweep started too soon after the last one.
    always_comb begin
        ovf_err_d = ovf_err_q | drop | early;
    end

    // Control registers with synchronous reset.
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            smp_v_q      <= 1'b0;
            pt_q         <= '0;
            sw_q         <= '0;
            gap_q        <= GAP_MIN;
            s1_v_q       <= 1'b0;
            fwd_v_q      <= 1'b0;
            dump_idx_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            ovf_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            smp_v_q      <= smp_v_d;
            pt_q         <= pt_d;
            sw_q         <= sw_d;
            gap_q        <= gap_d;
            s1_v_q       <= s1_v_d;
            fwd_v_q      <= fwd_v_d;
            dump_idx_q   <= dump_idx_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            ovf_err_q    <= ovf_err_d;
        end
    end

    // Pipeline payload registers; qualified by the reset valid bits above.
    always_ff @(posedge clk) begin
        s1_first_q <= s1_first_d;
        s1_addr_q  <= s1_addr_d;
        s1_data_q  <= s1_data_d;
        fwd_addr_q <= fwd_addr_d;
        fwd_data_q <= fwd_data_d;
    end

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_data  = out_valid_q ? ram_rdata : '0;
    assign out_if.out_index = dump_idx_q;
    assign busy             = (state_q == DUMP);
    assign frame_done       = frame_done_q;
    assign ovf_err          = ovf_err_q;

endmodule

// File: tb/tb_point_accumulator.sv
// Self-checking bench: randomized sweeps against a per-point running-sum model.
module tb_point_accumulator;
    import raman_pkg::*;

    localparam int NPT    = 11;
    localparam int MEAS_A = 3;
    localparam int MEAS_B = 100;
    localparam longint unsigned SUM_MOD = 64'd1 << SUM_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdreq_a, rdreq_b;
    logic [DATA_W-1:0] data_a, data_b;
    logic              busy_a, busy_b, fd_a, fd_b, ovf_a, ovf_b;

    point_accumulator_if if_a ();
    point_accumulator_if if_b ();

    always #5 clk = ~clk;

    point_accumulator #(.POINTS(NPT - 1), .MEASURES(MEAS_A), .DATA_W(DATA_W)) dut_a (
        .clk(clk), .rst(rst), .rdreq(rdreq_a), .data_in(data_a), .out_if(if_a),
        .busy(busy_a), .frame_done(fd_a), .ovf_err(ovf_a)
    );

    point_accumulator #(.POINTS(NPT - 1), .MEASURES(MEAS_B), .DATA_W(DATA_W)) dut_b (
        .clk(clk), .rst(rst), .rdreq(rdreq_b), .data_in(data_b), .out_if(if_b),
        .busy(busy_b), .frame_done(fd_b), .ovf_err(ovf_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        bit                v;
        logic [DATA_W-1:0] d;
    } beat_t;

    beat_t           stim_q[$];
    longint unsigned model_sum [NPT];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic void model_reset();
        foreach (model_sum[i]) model_sum[i] = 0;
        stim_q.delete();
    endfunction

    function automatic longint unsigned expected(input int i);
        return model_sum[i] % SUM_MOD;
    endfunction

    function automatic void push_idle(input int n);
        for (int k = 0; k < n; k++) stim_q.push_back('{v: 1'b0, d: '0});
    endfunction

    // mode 0: ramp pt+1, 1: random, 2: full scale. Only samples are summed in the model.
    function automatic void add_sweep(input int mode, input int lead, input bit gappy, input int npts);
        logic [DATA_W-1:0] val;
        push_idle(lead);
        for (int p = 0; p < npts; p++) begin
            case (mode)
                0:       val = DATA_W'(p + 1);
                1:       val = DATA_W'($urandom);
                default: val = '1;
            endcase
            if (gappy && p > 0 && $urandom_range(0, 3) == 0) push_idle($urandom_range(1, 2));
            stim_q.push_back('{v: 1'b1, d: val});
            model_sum[p] += val;
        end
    endfunction

    task automatic set_in(input bit sel, input logic v, input logic [DATA_W-1:0] d);
        if (sel) begin rdreq_b = v; data_b = d; end
        else     begin rdreq_a = v; data_a = d; end
    endtask

    task automatic set_ready(input bit sel, input logic r);
        if (sel) if_b.out_ready = r;
        else     if_a.out_ready = r;
    endtask

    task automatic peek(input bit sel, output logic v, output logic [SUM_W-1:0] d,
                        output logic [IDX_W-1:0] idx, output logic fd, output logic bz,
                        output logic ovf);
        if (sel) begin
            v = if_b.out_valid; d = if_b.out_data; idx = if_b.out_index;
            fd = fd_b; bz = busy_b; ovf = ovf_b;
        end else begin
            v = if_a.out_valid; d = if_a.out_data; idx = if_a.out_index;
            fd = fd_a; bz = busy_a; ovf = ovf_a;
        end
    endtask

    // FIFO-like playback: data_in carries the sample one cycle after its rdreq.
    task automatic play(input bit sel);
        bit                prev_v = 1'b0;
        logic [DATA_W-1:0] prev_d = '0;
        foreach (stim_q[i]) begin
            @(negedge clk);
            set_in(sel, stim_q[i].v, prev_v ? prev_d : DATA_W'($urandom));
            prev_v = stim_q[i].v;
            prev_d = stim_q[i].d;
        end
        @(negedge clk);
        set_in(sel, 1'b0, prev_v ? prev_d : DATA_W'($urandom));
        @(negedge clk);
        set_in(sel, 1'b0, DATA_W'($urandom));
    endtask

    task automatic check_ovf(input bit sel, input string tag, input logic exp);
        logic v, fd, bz, ovf;
        logic [SUM_W-1:0] d;
        logic [IDX_W-1:0] idx;
        peek(sel, v, d, idx, fd, bz, ovf);
        check(tag, ovf, exp);
    endtask

    // Drain one dump, checking each point against the model; optional stall and
    // optional rdreq pulse while the stalled point is held.
    task automatic collect(input bit sel, input string tag, input int stall_idx,
                           input int stall_len, input int poke_idx);
        logic v, fd, bz, ovf;
        logic [SUM_W-1:0] d;
        logic [IDX_W-1:0] idx;
        int waited, nstall;
        for (int i = 0; i < NPT; i++) begin
            set_ready(sel, 1'b0);
            waited = 0;
            peek(sel, v, d, idx, fd, bz, ovf);
            while (!v && waited < 30) begin
                @(negedge clk);
                waited++;
                peek(sel, v, d, idx, fd, bz, ovf);
            end
            check($sformatf("%s_valid%0d", tag, i), v, 1);
            check($sformatf("%s_busy%0d", tag, i), bz, 1);
            check($sformatf("%s_index%0d", tag, i), idx, i);
            check($sformatf("%s_data%0d", tag, i), d, expected(i));
            nstall = (i == stall_idx) ? stall_len : $urandom_range(0, 1);
            for (int s = 0; s < nstall; s++) begin
                set_in(sel, (i == poke_idx && s == 0), DATA_W'($urandom));
                @(negedge clk);
                peek(sel, v, d, idx, fd, bz, ovf);
                check($sformatf("%s_hold_valid%0d", tag, i), v, 1);
                check($sformatf("%s_hold_index%0d", tag, i), idx, i);
                check($sformatf("%s_hold_data%0d", tag, i), d, expected(i));
            end
            set_in(sel, 1'b0, DATA_W'($urandom));
            set_ready(sel, 1'b1);
            @(negedge clk);
            peek(sel, v, d, idx, fd, bz, ovf);
            check($sformatf("%s_frame_done%0d", tag, i), fd, (i == NPT - 1));
        end
        set_ready(sel, 1'b0);
        check({tag, "_busy_end"}, bz, 0);
        check({tag, "_valid_end"}, v, 0);
        @(negedge clk);
        peek(sel, v, d, idx, fd, bz, ovf);
        check({tag, "_frame_done_pulse"}, fd, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(1'b0, 1'b0, '0);
        set_in(1'b1, 1'b0, '0);
        set_ready(1'b0, 1'b0);
        set_ready(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic v, fd, bz, ovf;
        logic [SUM_W-1:0] d;
        logic [IDX_W-1:0] idx;

        do_reset();
        for (int s = 0; s < 2; s++) begin
            peek(s[0], v, d, idx, fd, bz, ovf);
            check($sformatf("rst_valid_%0d", s), v, 0);
            check($sformatf("rst_data_%0d", s), d, 0);
            check($sformatf("rst_index_%0d", s), idx, 0);
            check($sformatf("rst_busy_%0d", s), bz, 0);
            check($sformatf("rst_frame_done_%0d", s), fd, 0);
            check($sformatf("rst_ovf_%0d", s), ovf, 0);
        end

        // Ramp sweeps: each point sums to 3*(pt+1).
        model_reset();
        for (int s = 0; s < MEAS_A; s++) add_sweep(0, 3, 1'b0, NPT);
        play(1'b0);
        check_ovf(1'b0, "ramp_ovf", 0);
        collect(1'b0, "ramp", -1, 0, -1);

        // Random gappy sweeps with a 5-cycle backpressure stall at index 4.
        model_reset();
        for (int s = 0; s < MEAS_A; s++) add_sweep(1, $urandom_range(2, 4), 1'b1, NPT);
        play(1'b0);
        check_ovf(1'b0, "stall_ovf", 0);
        collect(1'b0, "stall", 4, 5, -1);

        // Sweeps started too early: flagged, still summed.
        model_reset();
        add_sweep(1, 3, 1'b0, NPT);
        add_sweep(1, 0, 1'b0, NPT);
        add_sweep(1, 1, 1'b0, NPT);
        play(1'b0);
        check_ovf(1'b0, "early_ovf", 1);
        collect(1'b0, "early", -1, 0, -1);
        check_ovf(1'b0, "early_ovf_sticky", 1);

        do_reset();
        check_ovf(1'b0, "rst_clears_ovf", 0);

        // rdreq during dump: sample dropped, flagged, sums untouched.
        model_reset();
        for (int s = 0; s < MEAS_A; s++) add_sweep(1, $urandom_range(2, 4), 1'b1, NPT);
        play(1'b0);
        check_ovf(1'b0, "poke_ovf_before", 0);
        collect(1'b0, "poke", 3, 3, 3);
        check_ovf(1'b0, "poke_ovf", 1);

        // Reset in the middle of sweep 2, then three clean ramp sweeps.
        do_reset();
        model_reset();
        add_sweep(1, 2, 1'b0, NPT);
        add_sweep(1, 2, 1'b0, NPT);
        add_sweep(1, 2, 1'b0, 5);
        play(1'b0);
        do_reset();
        model_reset();
        for (int s = 0; s < MEAS_A; s++) add_sweep(0, 3, 1'b0, NPT);
        play(1'b0);
        check_ovf(1'b0, "midrst_ovf", 0);
        collect(1'b0, "midrst", -1, 0, -1);

        // Further random frames with random stalls.
        for (int f = 0; f < 2; f++) begin
            model_reset();
            for (int s = 0; s < MEAS_A; s++) add_sweep(1, $urandom_range(2, 5), 1'b1, NPT);
            play(1'b0);
            check_ovf(1'b0, $sformatf("rand%0d_ovf", f), 0);
            collect(1'b0, $sformatf("rand%0d", f), $urandom_range(0, NPT - 1),
                    $urandom_range(1, 4), -1);
        end

        // Full-scale samples over 100 sweeps at the minimum legal gap.
        model_reset();
        add_sweep(2, 3, 1'b0, NPT);
        for (int s = 1; s < MEAS_B; s++) add_sweep(2, 2, 1'b0, NPT);
        play(1'b1);
        check_ovf(1'b1, "full_ovf", 0);
        collect(1'b1, "full", 6, 2, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
